core_immenc: RTL and testbench
==============================

CORE_IMMENC -- requirements
Module: core_immenc

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: in_valid  in  1  request present.
REQ-004 SHALL have ports: in_ready  out  1  request accepted when in_valid & in_ready at clk edge.
REQ-005 SHALL have ports: in_opcode  in  5  RV32I major opcode bits [6:2] (OPIMM, LOAD, STORE, BRANCH, LUI, AUIPC, JALR, JAL).
REQ-006 SHALL have ports: in_rd, in_rs1, in_rs2  in  5 each  register fields.
REQ-007 SHALL have ports: in_funct3  in  3  funct3 field.
REQ-008 SHALL have ports: in_imm  in  32  signed byte-value immediate (not pre-shifted).
REQ-009 SHALL have ports: out_valid  out  1  encoded word present.
REQ-010 SHALL have ports: out_ready  in  1  consumer takes word when out_valid & out_ready.
REQ-011 SHALL have ports: out_ir  out  32  encoded instruction, ir[1:0]=2'b11.
REQ-012 SHALL have ports: err  out  1  one-cycle pulse: last accepted request was rejected.

Function
REQ-013 SHALL encode the inverse of the core immediate decoder: I-type (OPIMM, LOAD, JALR) ir[31:20]=imm[11:0]; S-type ir[31:25]=imm[11:5], ir[11:7]=imm[4:0]; B-type ir[31]=imm[12], ir[7]=imm[11], ir[30:25]=imm[10:5], ir[11:8]=imm[4:1]; U-type ir[31:12]=imm[31:12]; J-type ir[31]=imm[20], ir[19:12]=imm[19:12], ir[20]=imm[11], ir[30:21]=imm[10:1].
REQ-014 SHALL place rd/rs1/rs2/funct3 only in fields the format defines; JALR funct3 forced 000; ir[6:0]={in_opcode,2'b11}.
REQ-015 SHALL reject (err, no output word): unknown opcode; I/S immediate outside [-2048,2047] except REQ-016 case; B outside [-4096,4094] or imm[0]=1; J outside [-1048576,1048574] or imm[0]=1; LUI/AUIPC with imm[11:0]!=0.
REQ-016 SHALL expand OPIMM, funct3=000, rs1=x0, imm outside 12-bit range into LUI rd,hi then ADDI rd,rd,lo: hi=(imm+0x800)>>12 (mod 2^20), lo=imm[11:0]; if lo=0 emit LUI only. Same case with rs1!=x0 SHALL be rejected.
REQ-017 SHALL use FSM IDLE, OUT1, OUT2; in_ready=1 only in IDLE.
REQ-018 IDLE, accept valid request: load out_ir with first word, out_valid=1 next cycle, go OUT1; rejected request: err=1 next cycle only, stay IDLE.
REQ-019 OUT1 with out_ready=1: second word pending -> load ADDI, go OUT2; else out_valid=0, go IDLE.
REQ-020 OUT2 with out_ready=1: out_valid=0, go IDLE.
REQ-021 out_ready=0 SHALL hold out_ir, out_valid and state unchanged (no drop, no duplicate).
REQ-022 Latency: first word valid the cycle after acceptance; max throughput one request per 2 cycles (3 for expansions).
REQ-023 Request inputs SHALL be sampled only at acceptance; later changes SHALL not affect emitted words.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, out_valid=0, err=0, out_ir=0, pending word discarded; in_ready=1 after rst deasserts.

Verification
REQ-025 ADDI x5,x0,5 (op 00100, rd 5, imm 5) -> out_ir 0x00500293, one word.
REQ-026 li x5,0x12345678 (OPIMM, f3 0, rs1 0) -> 0x123452B7 then 0x67828293; imm 0x800 -> 0x000012B7 then 0x80028293; imm 0x1000 -> 0x000012B7 only.
REQ-027 BRANCH f3 000, rs1 1, rs2 2, imm -4 -> 0xFE208EE3.
REQ-028 BRANCH imm 3, JAL imm 0x100000, LUI imm 0x123 -> err one-cycle pulse each, out_valid stays 0, in_ready 1 next cycle.
REQ-029 li expansion with out_ready=0 for 3 cycles -> out_ir holds 0x123452B7, in_ready=0 throughout; ADDI follows exactly once.
REQ-030 rst asserted in OUT1 of expansion -> out_valid=0 same cycle, ADDI never emitted, next request encodes normally.

Source files
------------

// File: rtl/core_immenc.sv
`default_nettype none
// ============================================================================
// Module      : core_immenc
// Description : RV32I instruction encoder, the inverse of the core immediate
//               decoder. It takes an opcode, register fields, funct3 and a
//               byte-value immediate and emits the encoded 32-bit word over a
//               valid/ready stream. A large-constant ADDI from x0 is expanded
//               into LUI + ADDI. Illegal requests raise a one-cycle err pulse
//               and emit no word.
// Ports       : clk        - clock, all state on rising edge
//               rst        - asynchronous active-high reset
//               in_valid   - request present
//               in_ready   - request accepted when in_valid & in_ready
//               in_opcode  - instruction bits [6:2]
//               in_rd/in_rs1/in_rs2 - register fields
//               in_funct3  - funct3 field
//               in_imm     - signed immediate, byte value (not pre-shifted)
//               out_valid  - encoded word present
//               out_ready  - consumer takes word when out_valid & out_ready
//               out_ir     - encoded instruction
//               err        - one-cycle pulse, last accepted request rejected
// Revision    : 1.0 - initial release
// ============================================================================
module core_immenc (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ir,
    output logic        err
);

    localparam logic [4:0] c_OP_LOAD   = 5'b00000;
    localparam logic [4:0] c_OP_OPIMM  = 5'b00100;
    localparam logic [4:0] c_OP_AUIPC  = 5'b00101;
    localparam logic [4:0] c_OP_STORE  = 5'b01000;
    localparam logic [4:0] c_OP_LUI    = 5'b01101;
    localparam logic [4:0] c_OP_BRANCH = 5'b11000;
    localparam logic [4:0] c_OP_JALR   = 5'b11001;
    localparam logic [4:0] c_OP_JAL    = 5'b11011;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_OUT1 = 2'd1;
    localparam logic [1:0] c_S_OUT2 = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_ir;
    logic [31:0] r_second;
    logic        r_pend;
    logic        r_out_valid;
    logic        r_err;

    // Range checks: a value fits N signed bits when all bits from N-1 upward
    // are copies of the sign.
    logic        w_fits12;
    logic        w_fits_b;
    logic        w_fits_j;
    logic        w_lo_zero;
    logic [19:0] w_hi;
    logic [6:0]  w_op7;

    logic        w_reject;
    logic        w_two;
    logic [31:0] w_first;
    logic [31:0] w_second;

    assign w_fits12  = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign w_fits_b  = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
    assign w_fits_j  = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
    assign w_lo_zero = (in_imm[11:0] == 12'd0);
    // (imm + 0x800) >> 12 : rounding compensates the sign-extended ADDI low part
    assign w_hi      = in_imm[31:12] + {19'd0, in_imm[11]};
    assign w_op7     = {in_opcode, 2'b11};

    always_comb begin
        w_reject = 1'b0;
        w_two    = 1'b0;
        w_first  = 32'd0;
        w_second = 32'd0;
        case (in_opcode)
            c_OP_OPIMM: begin
                if (w_fits12) begin
                    w_first = {in_imm[11:0], in_rs1, in_funct3, in_rd, w_op7};
                end else if ((in_funct3 == 3'b000) && (in_rs1 == 5'd0)) begin
                    // li expansion: LUI rd,hi then ADDI rd,rd,lo (omitted when lo=0)
                    w_first  = {w_hi, in_rd, c_OP_LUI, 2'b11};
                    w_second = {in_imm[11:0], in_rd, 3'b000, in_rd, c_OP_OPIMM, 2'b11};
                    w_two    = ~w_lo_zero;
                end else begin
                    w_reject = 1'b1;
                end
            end
            c_OP_LOAD: begin
                w_reject = ~w_fits12;
                w_first  = {in_imm[11:0], in_rs1, in_funct3, in_rd, w_op7};
            end
            c_OP_JALR: begin
                w_reject = ~w_fits12;
                w_first  = {in_imm[11:0], in_rs1, 3'b000, in_rd, w_op7};
            end
            c_OP_STORE: begin
                w_reject = ~w_fits12;
                w_first  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], w_op7};
            end
            c_OP_BRANCH: begin
                w_reject = ~w_fits_b;
                w_first  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], w_op7};
            end
            c_OP_LUI, c_OP_AUIPC: begin
                w_reject = ~w_lo_zero;
                w_first  = {in_imm[31:12], in_rd, w_op7};
            end
            c_OP_JAL: begin
                w_reject = ~w_fits_j;
                w_first  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, w_op7};
            end
            default: begin
                w_reject = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_ir        <= 32'd0;
            r_second    <= 32'd0;
            r_pend      <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (in_valid) begin
                        if (w_reject) begin
                            r_err <= 1'b1;
                        end else begin
                            r_ir        <= w_first;
                            r_second    <= w_second;
                            r_pend      <= w_two;
                            r_out_valid <= 1'b1;
                            r_state     <= c_S_OUT1;
                        end
                    end
                end
                c_S_OUT1: begin
                    if (out_ready) begin
                        if (r_pend) begin
                            r_ir    <= r_second;
                            r_pend  <= 1'b0;
                            r_state <= c_S_OUT2;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_state     <= c_S_IDLE;
                        end
                    end
                end
                c_S_OUT2: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_pend      <= 1'b0;
                    r_state     <= c_S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_S_IDLE);
    assign out_valid = r_out_valid;
    assign out_ir    = r_ir;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_core_immenc.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_immenc
// Description : Self-checking bench for core_immenc. Directed encodings,
//               rejects, stalls and reset-in-flight, followed by randomized
//               requests checked against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_immenc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ir;
    logic        err;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    core_immenc dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ir    (out_ir),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: encoding built field by field from the ISA formats,
    // legality decided with signed integer range comparisons.
    task automatic model(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
                         output bit rej, output int n, output logic [31:0] w0, output logic [31:0] w1);
        int          si;
        logic [31:0] opf;
        logic [31:0] hi;
        logic [31:0] lo;
        si  = int'(imm);
        opf = (32'(op) << 2) | 32'd3;
        rej = 1'b0;
        n   = 1;
        w0  = 32'd0;
        w1  = 32'd0;
        case (op)
            5'b00100, 5'b00000, 5'b11001: begin
                if (si >= -2048 && si <= 2047) begin
                    w0 = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15)
                       | ((op == 5'b11001) ? 32'd0 : (32'(f3) << 12)) | (32'(rd) << 7) | opf;
                end else if (op == 5'b00100 && f3 == 3'd0 && rs1 == 5'd0) begin
                    hi = ((imm + 32'h800) >> 12) & 32'hFFFFF;
                    lo = imm & 32'hFFF;
                    w0 = (hi << 12) | (32'(rd) << 7) | 32'h37;
                    if (lo != 0) begin
                        n  = 2;
                        w1 = (lo << 20) | (32'(rd) << 15) | (32'(rd) << 7) | 32'h13;
                    end
                end else begin
                    rej = 1'b1;
                end
            end
            5'b01000: begin
                rej = !(si >= -2048 && si <= 2047);
                w0  = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                    | (32'(f3) << 12) | ((imm & 32'h1F) << 7) | opf;
            end
            5'b11000: begin
                rej = !(si >= -4096 && si <= 4094 && imm[0] == 1'b0);
                w0  = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                    | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                    | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | opf;
            end
            5'b01101, 5'b00101: begin
                rej = (imm % 4096) != 0;
                w0  = (imm & 32'hFFFFF000) | (32'(rd) << 7) | opf;
            end
            5'b11011: begin
                rej = !(si >= -1048576 && si <= 1048574 && imm[0] == 1'b0);
                w0  = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                    | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                    | (32'(rd) << 7) | opf;
            end
            default: rej = 1'b1;
        endcase
        if (rej) n = 0;
    endtask

    // One request: present at a negedge, accepted at the following posedge,
    // inputs scrambled afterwards; each word is stalled `stalls` cycles.
    task automatic do_req(input string tag, input logic [4:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [31:0] imm, input bit exp_rej, input int exp_n,
                          input logic [31:0] e0, input logic [31:0] e1, input int stalls);
        logic [31:0] exp_w;
        @(negedge clk);
        check({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_imm    = imm;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid  = 1'b0;
        in_opcode = 5'($urandom);
        in_rd     = 5'($urandom);
        in_rs1    = 5'($urandom);
        in_rs2    = 5'($urandom);
        in_funct3 = 3'($urandom);
        in_imm    = $urandom;
        if (exp_rej) begin
            check({tag, "_err"}, 32'(err), 32'd1);
            check({tag, "_valid_rej"}, 32'(out_valid), 32'd0);
            check({tag, "_ready_rej"}, 32'(in_ready), 32'd1);
            @(negedge clk);
            check({tag, "_err_end"}, 32'(err), 32'd0);
        end else begin
            for (int w = 0; w < exp_n; w++) begin
                exp_w = (w == 0) ? e0 : e1;
                for (int s = 0; s < stalls; s++) begin
                    check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
                    check({tag, "_stall_ir"}, out_ir, exp_w);
                    check({tag, "_stall_ready"}, 32'(in_ready), 32'd0);
                    @(negedge clk);
                end
                check({tag, "_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_ir"}, out_ir, exp_w);
                check({tag, "_err_ok"}, 32'(err), 32'd0);
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
            end
            check({tag, "_valid_done"}, 32'(out_valid), 32'd0);
            check({tag, "_ready_done"}, 32'(in_ready), 32'd1);
        end
    endtask

    task automatic req_model(input string tag, input logic [4:0] op, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                             input logic [31:0] imm, input int stalls);
        bit          rej;
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        model(op, rd, rs1, rs2, f3, imm, rej, n, w0, w1);
        do_req(tag, op, rd, rs1, rs2, f3, imm, rej, n, w0, w1, stalls);
    endtask

    localparam logic [4:0] OPS [8] = '{5'b00100, 5'b00000, 5'b01000, 5'b11000,
                                       5'b01101, 5'b00101, 5'b11001, 5'b11011};
    localparam logic [31:0] EDGES [10] = '{32'd2047, 32'hFFFFF800, 32'd2048, 32'hFFFFF7FF,
                                           32'd4094, 32'hFFFFF000, 32'd4096, 32'd1048574,
                                           32'hFFF00000, 32'd1048576};

    initial begin
        logic [4:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [31:0] imm;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_opcode = 5'd0;
        in_rd     = 5'd0;
        in_rs1    = 5'd0;
        in_rs2    = 5'd0;
        in_funct3 = 3'd0;
        in_imm    = 32'd0;
        out_ready = 1'b0;
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ir", out_ir, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);

        // Known encodings
        do_req("addi", 5'b00100, 5'd5, 5'd0, 5'd0, 3'd0, 32'd5, 1'b0, 1, 32'h00500293, 32'd0, 0);
        do_req("li_big", 5'b00100, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345678, 1'b0, 2,
               32'h123452B7, 32'h67828293, 0);
        do_req("li_800", 5'b00100, 5'd5, 5'd0, 5'd0, 3'd0, 32'h00000800, 1'b0, 2,
               32'h000012B7, 32'h80028293, 1);
        do_req("li_1000", 5'b00100, 5'd5, 5'd0, 5'd0, 3'd0, 32'h00001000, 1'b0, 1,
               32'h000012B7, 32'd0, 0);
        do_req("beq_m4", 5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFFFFFC, 1'b0, 1,
               32'hFE208EE3, 32'd0, 0);
        do_req("rej_b3", 5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3, 1'b1, 0, 32'd0, 32'd0, 0);
        do_req("rej_jal", 5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00100000, 1'b1, 0, 32'd0, 32'd0, 0);
        do_req("rej_lui", 5'b01101, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00000123, 1'b1, 0, 32'd0, 32'd0, 0);
        do_req("rej_li_rs1", 5'b00100, 5'd5, 5'd3, 5'd0, 3'd0, 32'h12345678, 1'b1, 0, 32'd0, 32'd0, 0);
        do_req("rej_unk", 5'b11111, 5'd5, 5'd0, 5'd0, 3'd0, 32'd0, 1'b1, 0, 32'd0, 32'd0, 0);
        do_req("li_stall3", 5'b00100, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345678, 1'b0, 2,
               32'h123452B7, 32'h67828293, 3);
        do_req("jalr_f3", 5'b11001, 5'd1, 5'd2, 5'd0, 3'd7, 32'd8, 1'b0, 1, 32'h008100E7, 32'd0, 0);

        // Reset while the first word of an expansion is outstanding
        @(negedge clk);
        in_valid  = 1'b1;
        in_opcode = 5'b00100;
        in_rd     = 5'd5;
        in_rs1    = 5'd0;
        in_rs2    = 5'd0;
        in_funct3 = 3'd0;
        in_imm    = 32'h12345678;
        @(negedge clk);
        in_valid = 1'b0;
        check("rstmid_first", out_ir, 32'h123452B7);
        #1 rst = 1'b1;
        #1;
        check("rstmid_valid", 32'(out_valid), 32'd0);
        check("rstmid_ir", out_ir, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rstmid_ready", 32'(in_ready), 32'd1);
        check("rstmid_noaddi", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("rstmid_noaddi2", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        do_req("post_rst", 5'b00100, 5'd5, 5'd0, 5'd0, 3'd0, 32'd5, 1'b0, 1, 32'h00500293, 32'd0, 0);

        // Range boundaries against the model
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 8; k++) begin
                req_model("edge", OPS[k], 5'd7, 5'd0, 5'd9, 3'd0, EDGES[i], 0);
            end
        end

        // Randomized requests
        for (int i = 0; i < 250; i++) begin
            op  = ($urandom_range(0, 15) == 0) ? 5'($urandom) : OPS[$urandom_range(0, 7)];
            f3  = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom);
            rs1 = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
            case ($urandom_range(0, 4))
                0: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                1: imm = $urandom;
                2: imm = $urandom & 32'hFFFFF000;
                3: imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
                default: imm = EDGES[$urandom_range(0, 9)];
            endcase
            req_model("rand", op, 5'($urandom), rs1, 5'($urandom), f3, imm, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
